// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage operand alignment for floating-point add/sub.
// Stage 1 unpacks and classifies both operands; stage 2 shifts the smaller
// operand right to the common exponent and collects the sticky bit.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [EXP_W-1:0]   IN_EXP_A,
  input  logic [EXP_W-1:0]   IN_EXP_B,
  input  logic [MAN_W-1:0]   IN_MANT_A,
  input  logic [MAN_W-1:0]   IN_MANT_B,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [MAN_W+2:0]   OUT_MANT_A,
  output logic [MAN_W+2:0]   OUT_MANT_B,
  output logic [EXP_W-1:0]   OUT_EXP,
  output logic               STICKY_BIT,
  output logic               OUT_SWAP,
  output logic               EXC_FLAG,
  output logic               NAN_FLAG,
  output logic [CNT_W-1:0]   EXC_COUNT
);

  localparam int XW = MAN_W + 3;

  logic               s1_load, s2_load;

  logic               s1_valid_q, s1_valid_d;
  logic [XW-1:0]      s1_man_a_q, s1_man_a_d;
  logic [XW-1:0]      s1_man_b_q, s1_man_b_d;
  logic [EXP_W-1:0]   s1_diff_q, s1_diff_d;
  logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
  logic               s1_swap_q, s1_swap_d;
  logic               s1_exc_q, s1_exc_d;
  logic               s1_nan_q, s1_nan_d;

  logic               s2_valid_q, s2_valid_d;
  logic [XW-1:0]      s2_man_a_q, s2_man_a_d;
  logic [XW-1:0]      s2_man_b_q, s2_man_b_d;
  logic [EXP_W-1:0]   s2_exp_q, s2_exp_d;
  logic               s2_sticky_q, s2_sticky_d;
  logic               s2_swap_q, s2_swap_d;
  logic               s2_exc_q, s2_exc_d;
  logic               s2_nan_q, s2_nan_d;

  logic [CNT_W-1:0]   exc_cnt_q, exc_cnt_d;

  logic [EXP_W-1:0]   eff_a, eff_b;
  logic [XW-1:0]      ext_a, ext_b;
  logic               inf_a, inf_b;
  logic [XW-1:0]      shift_src, shifted;
  logic               sticky;

  // Handshake: a stage may load when empty or when the stage after it drains.
  always_comb begin
    s2_load  = !s2_valid_q || OUT_READY;
    s1_load  = !s1_valid_q || s2_load;
    IN_READY = s1_load;
  end

  // Stage 1: unpack, compare effective exponents, classify exceptions.
  always_comb begin
    eff_a = (IN_EXP_A == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : IN_EXP_A;
    eff_b = (IN_EXP_B == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : IN_EXP_B;
    ext_a = {(IN_EXP_A != '0), IN_MANT_A, 2'b00};
    ext_b = {(IN_EXP_B != '0), IN_MANT_B, 2'b00};
    inf_a = (IN_EXP_A == '1);
    inf_b = (IN_EXP_B == '1);

    s1_valid_d = s1_valid_q;
    s1_man_a_d = s1_man_a_q;
    s1_man_b_d = s1_man_b_q;
    s1_diff_d  = s1_diff_q;
    s1_exp_d   = s1_exp_q;
    s1_swap_d  = s1_swap_q;
    s1_exc_d   = s1_exc_q;
    s1_nan_d   = s1_nan_q;

    if (s1_load) begin
      s1_valid_d = IN_VALID;
      s1_man_a_d = ext_a;
      s1_man_b_d = ext_b;
      s1_exc_d   = inf_a || inf_b;
      s1_nan_d   = (inf_a && (IN_MANT_A != '0)) || (inf_b && (IN_MANT_B != '0));
      if (inf_a || inf_b) begin
        s1_swap_d = 1'b0;
        s1_diff_d = '0;
        s1_exp_d  = '1;
      end else if (eff_b > eff_a) begin
        s1_swap_d = 1'b1;
        s1_diff_d = eff_b - eff_a;
        s1_exp_d  = eff_b;
      end else begin
        s1_swap_d = 1'b0;
        s1_diff_d = eff_a - eff_b;
        s1_exp_d  = eff_a;
      end
    end
  end

  // Stage 2: right-shift the smaller operand and OR together every lost bit.
  always_comb begin
    shift_src = s1_swap_q ? s1_man_a_q : s1_man_b_q;
    shifted   = shift_src >> s1_diff_q;
    if (32'(s1_diff_q) >= XW) begin
      shifted = '0;
    end
    sticky = 1'b0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (i < 32'(s1_diff_q)) begin
        sticky = sticky | shift_src[i];
      end
    end

    s2_valid_d  = s2_valid_q;
    s2_man_a_d  = s2_man_a_q;
    s2_man_b_d  = s2_man_b_q;
    s2_exp_d    = s2_exp_q;
    s2_sticky_d = s2_sticky_q;
    s2_swap_d   = s2_swap_q;
    s2_exc_d    = s2_exc_q;
    s2_nan_d    = s2_nan_q;

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_exp_d   = s1_exp_q;
      s2_swap_d  = s1_swap_q;
      s2_exc_d   = s1_exc_q;
      s2_nan_d   = s1_nan_q;
      if (s1_exc_q) begin
        s2_man_a_d  = '0;
        s2_man_b_d  = '0;
        s2_sticky_d = 1'b0;
      end else if (s1_swap_q) begin
        s2_man_a_d  = shifted;
        s2_man_b_d  = s1_man_b_q;
        s2_sticky_d = sticky;
      end else begin
        s2_man_a_d  = s1_man_a_q;
        s2_man_b_d  = shifted;
        s2_sticky_d = sticky;
      end
    end
  end

  // Saturating count of exception results actually handed downstream.
  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (s2_valid_q && OUT_READY && s2_exc_q && (exc_cnt_q != '1)) begin
      exc_cnt_d = exc_cnt_q + 1'b1;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_man_a_q  <= '0;
      s1_man_b_q  <= '0;
      s1_diff_q   <= '0;
      s1_exp_q    <= '0;
      s1_swap_q   <= 1'b0;
      s1_exc_q    <= 1'b0;
      s1_nan_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_man_a_q  <= '0;
      s2_man_b_q  <= '0;
      s2_exp_q    <= '0;
      s2_sticky_q <= 1'b0;
      s2_swap_q   <= 1'b0;
      s2_exc_q    <= 1'b0;
      s2_nan_q    <= 1'b0;
      exc_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_man_a_q  <= s1_man_a_d;
      s1_man_b_q  <= s1_man_b_d;
      s1_diff_q   <= s1_diff_d;
      s1_exp_q    <= s1_exp_d;
      s1_swap_q   <= s1_swap_d;
      s1_exc_q    <= s1_exc_d;
      s1_nan_q    <= s1_nan_d;
      s2_valid_q  <= s2_valid_d;
      s2_man_a_q  <= s2_man_a_d;
      s2_man_b_q  <= s2_man_b_d;
      s2_exp_q    <= s2_exp_d;
      s2_sticky_q <= s2_sticky_d;
      s2_swap_q   <= s2_swap_d;
      s2_exc_q    <= s2_exc_d;
      s2_nan_q    <= s2_nan_d;
      exc_cnt_q   <= exc_cnt_d;
    end
  end

  assign OUT_VALID  = s2_valid_q;
  assign OUT_MANT_A = s2_man_a_q;
  assign OUT_MANT_B = s2_man_b_q;
  assign OUT_EXP    = s2_exp_q;
  assign STICKY_BIT = s2_sticky_q;
  assign OUT_SWAP   = s2_swap_q;
  assign EXC_FLAG   = s2_exc_q;
  assign NAN_FLAG   = s2_nan_q;
  assign EXC_COUNT  = exc_cnt_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Bench for fp_align_pipe at EXP_W=8, MAN_W=23, with a 4-bit exception
// counter so that saturation is reachable.
module tb_fp_align_pipe;

  logic        CLK, RST;
  logic        in_valid, out_ready;
  logic [7:0]  in_exp_a, in_exp_b;
  logic [22:0] in_mant_a, in_mant_b;
  logic        IN_READY, OUT_VALID;
  logic [25:0] OUT_MANT_A, OUT_MANT_B;
  logic [7:0]  OUT_EXP;
  logic        STICKY_BIT, OUT_SWAP, EXC_FLAG, NAN_FLAG;
  logic [3:0]  EXC_COUNT;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_exp = 0;
  logic fire_in, fire_out;
  logic [63:0] q[$];
  logic [63:0] act, expv;

  // Packed view of a result: {mant_a, mant_b, exp, sticky, swap, exc, nan}.
  assign act = {OUT_MANT_A, OUT_MANT_B, OUT_EXP, STICKY_BIT, OUT_SWAP, EXC_FLAG, NAN_FLAG};

  fp_align_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(in_valid), .IN_READY(IN_READY),
    .IN_EXP_A(in_exp_a), .IN_EXP_B(in_exp_b),
    .IN_MANT_A(in_mant_a), .IN_MANT_B(in_mant_b),
    .OUT_VALID(OUT_VALID), .OUT_READY(out_ready),
    .OUT_MANT_A(OUT_MANT_A), .OUT_MANT_B(OUT_MANT_B),
    .OUT_EXP(OUT_EXP), .STICKY_BIT(STICKY_BIT), .OUT_SWAP(OUT_SWAP),
    .EXC_FLAG(EXC_FLAG), .NAN_FLAG(NAN_FLAG), .EXC_COUNT(EXC_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: aligns two IEEE-style operands using integer arithmetic.
  function automatic logic [63:0] model(int ea, int fa, int eb, int fb);
    int xa, xb, d, e;
    logic swap, st, nan;
    longint ma, mb, m, sh, ra, rb, p;
    xa = (ea == 0) ? 1 : ea;
    xb = (eb == 0) ? 1 : eb;
    ma = ((ea != 0) ? 64'd33554432 : 64'd0) + longint'(fa) * 4;
    mb = ((eb != 0) ? 64'd33554432 : 64'd0) + longint'(fb) * 4;
    if (ea == 255 || eb == 255) begin
      nan = (ea == 255 && fa != 0) || (eb == 255 && fb != 0);
      return {52'd0, 8'hFF, 1'b0, 1'b0, 1'b1, nan};
    end
    swap = (xb > xa);
    e = swap ? xb : xa;
    d = swap ? xb - xa : xa - xb;
    m = swap ? ma : mb;
    if (d >= 26) begin
      sh = 0;
      st = (m != 0);
    end else begin
      p  = longint'(1) << d;
      sh = m / p;
      st = (m % p) != 0;
    end
    ra = swap ? sh : ma;
    rb = swap ? mb : sh;
    return {26'(ra), 26'(rb), 8'(e), st, swap, 1'b0, 1'b0};
  endfunction

  function automatic int rnd_exp(int base);
    int v;
    case ($urandom_range(0, 9))
      0: return 255;
      1: return 0;
      2, 3, 4, 5: begin
        v = base + int'($urandom_range(0, 60)) - 30;
        if (v < 0) v = 0;
        if (v > 254) v = 254;
        return v;
      end
      default: return int'($urandom_range(1, 254));
    endcase
  endfunction

  function automatic int rnd_frac();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 'h7FFFFF));
  endfunction

  // One clock: drive at the falling edge, then record which handshakes fire.
  task automatic step(input logic iv, input int ea, input int fa, input int eb,
                      input int fb, input logic ordy);
    @(negedge CLK);
    in_valid  = iv;
    in_exp_a  = 8'(ea);
    in_mant_a = 23'(fa);
    in_exp_b  = 8'(eb);
    in_mant_b = 23'(fb);
    out_ready = ordy;
    #1;
    fire_in  = in_valid & IN_READY;
    fire_out = OUT_VALID & out_ready;
    if (fire_in) q.push_back(model(ea, fa, eb, fb));
  endtask

  typedef struct {
    int ea, fa, eb, fb;
    logic [63:0] r;
  } dvec_t;

  dvec_t dv[6];

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    in_exp_a = '0; in_exp_b = '0; in_mant_a = '0; in_mant_b = '0;
    RST = 1'b0;
    #2 RST = 1'b1;
    #20;
    n_chk++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
    n_chk++;
    if (act !== 64'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", act); end
    n_chk++;
    if (EXC_COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_exc_count: got %0d expected 0", EXC_COUNT); end
    n_chk++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
    @(negedge CLK);
    RST = 1'b0;
    in_valid = 1'b1; in_exp_a = 8'd130; in_mant_a = '0; in_exp_b = 8'd126; in_mant_b = 23'd3;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL first_accept_ready: got %b expected 1", IN_READY); end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (OUT_VALID !== 1'b1 || OUT_EXP !== 8'd130) begin
      n_fail++; $display("FAIL first_accept_result: got valid=%b exp=%0d expected valid=1 exp=130", OUT_VALID, OUT_EXP);
    end
  endtask

  task automatic test_directed();
    dv[0] = '{130, 0,         126, 3,        {26'h2000000, 26'h0200000, 8'd130, 4'b1000}};
    dv[1] = '{1,   'h7FFFFF,  200, 0,        {26'h0000000, 26'h2000000, 8'd200, 4'b1100}};
    dv[2] = '{255, 1,         3,   5,        {26'h0000000, 26'h0000000, 8'd255, 4'b0011}};
    dv[3] = '{7,   9,         255, 0,        {26'h0000000, 26'h0000000, 8'd255, 4'b0010}};
    dv[4] = '{0,   'h400000,  0,   1,        {26'h1000000, 26'h0000004, 8'd1,   4'b0000}};
    dv[5] = '{100, 'h123456,  100, 'h654321, {26'h248D158, 26'h3950C84, 8'd100, 4'b0000}};
    for (int i = 0; i < 6; i++) begin
      step(1, dv[i].ea, dv[i].fa, dv[i].eb, dv[i].fb, 1);
      step(0, 0, 0, 0, 0, 1);
      n_chk++;
      if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b expected 0", i, OUT_VALID); end
      step(0, 0, 0, 0, 0, 1);
      n_chk++;
      if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: got %b expected 1", i, OUT_VALID); end
      n_chk++;
      if (act !== dv[i].r) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, act, dv[i].r); end
      n_chk++;
      if (EXC_COUNT !== 4'(cnt_exp)) begin n_fail++; $display("FAIL dir%0d_exc_count: got %0d expected %0d", i, EXC_COUNT, cnt_exp); end
      if (dv[i].r[1]) cnt_exp++;
    end
    step(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (EXC_COUNT !== 4'd2) begin n_fail++; $display("FAIL dir_exc_count_final: got %0d expected 2", EXC_COUNT); end
    q.delete();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int k;
    for (int c = 0; c < 4; c++) begin
      step(1, dv[sent].ea, dv[sent].fa, dv[sent].eb, dv[sent].fb, 0);
      if (fire_in) sent++;
      if (c >= 2) begin
        n_chk++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, IN_READY); end
        n_chk++;
        if (OUT_VALID !== 1'b1 || q.size() == 0 || act !== q[0]) begin
          n_fail++; $display("FAIL bp_hold_c%0d: got valid=%b data=%h", c, OUT_VALID, act);
        end
      end
    end
    n_chk++;
    if (sent !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
    for (int c = 0; c < 20 && !(got == 4 && sent == 4); c++) begin
      k = (sent < 4) ? sent : 0;
      step(sent < 4, dv[k].ea, dv[k].fa, dv[k].eb, dv[k].fb, 1);
      if (fire_in) sent++;
      if (fire_out) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_output: got %h expected none", act);
        end else begin
          expv = q.pop_front();
          if (act !== expv) begin n_fail++; $display("FAIL bp_order: got %h expected %h", act, expv); end
          if (expv[1] && cnt_exp < 15) cnt_exp++;
        end
        got++;
      end
    end
    n_chk++;
    if (got !== 4 || q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs, %0d pending, expected 4 and 0", got, q.size());
    end
  endtask

  task automatic test_random();
    int ea, eb;
    for (int c = 0; c < 500; c++) begin
      ea = rnd_exp(128);
      eb = rnd_exp(ea == 255 ? 128 : ea);
      if (c < 480)
        step($urandom_range(0, 3) != 0, ea, rnd_frac(), eb, rnd_frac(), $urandom_range(0, 9) < 7);
      else
        step(0, 0, 0, 0, 0, 1);
      n_chk++;
      if (EXC_COUNT !== 4'(cnt_exp)) begin
        n_fail++; $display("FAIL rnd_exc_count: got %0d expected %0d at cycle %0d", EXC_COUNT, cnt_exp, c);
      end
      if (fire_out) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_output: got %h expected none", act);
        end else begin
          expv = q.pop_front();
          if (act !== expv) begin n_fail++; $display("FAIL rnd_result: got %h expected %h", act, expv); end
          if (expv[1] && cnt_exp < 15) cnt_exp++;
        end
      end
    end
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d pending expected 0", q.size()); end
  endtask

  task automatic test_reset_midstream();
    step(1, dv[0].ea, dv[0].fa, dv[0].eb, dv[0].fb, 0);
    step(1, dv[2].ea, dv[2].fa, dv[2].eb, dv[2].fb, 0);
    in_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    n_chk++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", OUT_VALID); end
    n_chk++;
    if (EXC_COUNT !== 4'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", EXC_COUNT); end
    n_chk++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", IN_READY); end
    q.delete();
    cnt_exp = 0;
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 0, 0, 1);
      n_chk++;
      if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale_c%0d: got %b expected 0", c, OUT_VALID); end
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 26; c++) begin
      if (c < 20)
        step(1, 255, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), rnd_frac(), 1);
      else
        step(0, 0, 0, 0, 0, 1);
      n_chk++;
      if (EXC_COUNT !== 4'(cnt_exp)) begin
        n_fail++; $display("FAIL sat_exc_count: got %0d expected %0d at cycle %0d", EXC_COUNT, cnt_exp, c);
      end
      if (fire_out) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL sat_extra_output: got %h expected none", act);
        end else begin
          expv = q.pop_front();
          if (act !== expv) begin n_fail++; $display("FAIL sat_result: got %h expected %h", act, expv); end
          if (expv[1] && cnt_exp < 15) cnt_exp++;
        end
      end
    end
    n_chk++;
    if (EXC_COUNT !== 4'd15) begin n_fail++; $display("FAIL sat_final: got %0d expected 15", EXC_COUNT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
FP_ALIGN_PIPE -- requirements
Module: fp_align_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits; the block SHALL support values 5..11.
REQ-002 Parameter MAN_W, default 23, stored fraction width in bits; the block SHALL support values 10..52.
REQ-003 Parameter CNT_W, default 16, exception counter width in bits.
REQ-004 CLK  input  1  the block's one clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 IN_VALID  input  1  the input operand pair is valid this cycle.
REQ-007 IN_READY  output  1  the block can accept an operand pair this cycle.
REQ-008 IN_EXP_A, IN_EXP_B  input  EXP_W  biased exponents of operands A and B.
REQ-009 IN_MANT_A, IN_MANT_B  input  MAN_W  stored fractions, without the hidden bit.
REQ-010 OUT_VALID  output  1  the output result is valid this cycle.
REQ-011 OUT_READY  input  1  the downstream consumer accepts the result this cycle.
REQ-012 OUT_MANT_A, OUT_MANT_B  output  MAN_W+3  aligned mantissas, arranged as {hidden, fraction, guard, round}.
REQ-013 OUT_EXP  output  EXP_W  common exponent.
REQ-014 STICKY_BIT  output  1  OR of all bits shifted out beyond the round position.
REQ-015 OUT_SWAP  output  1  set when B had the larger exponent, so A was the operand shifted.
REQ-016 EXC_FLAG  output  1  at least one operand is Inf or NaN.
REQ-017 NAN_FLAG  output  1  at least one operand is NaN.
REQ-018 EXC_COUNT  output  CNT_W  number of results delivered with EXC_FLAG=1, saturating.

Function
REQ-019 Unpacking SHALL work as follows: an exponent of 0 gives effective exponent 1 and hidden bit 0 (denormal); any other exponent gives the exponent unchanged and hidden bit 1. Each unpacked operand SHALL be extended to {hidden, frac, 2'b00}.
REQ-020 A transfer SHALL occur on any cycle with VALID=1 and READY=1; a transfer only occurs on such a cycle.
REQ-021 The block SHALL be a 2-stage pipeline. Stage 1 SHALL register the unpacked operands, the exponent difference, the larger exponent, the swap decision and the exception class. Stage 2 SHALL register the shift result, sticky and flags.
REQ-022 Latency SHALL be 2 cycles from an input transfer to OUT_VALID, with no stall. Throughput SHALL be 1 transfer per cycle.
REQ-023 Stage 2 SHALL load when s2_valid=0 or OUT_READY=1. Stage 1 SHALL load when s1_valid=0 or stage 2 loads. IN_READY SHALL equal the stage-1 load condition. IN_READY SHALL be combinational and SHALL NOT depend on IN_VALID.
REQ-024 When OUT_VALID=1 and OUT_READY=0, every output SHALL hold stable and no data SHALL be lost or duplicated.
REQ-025 When exp_a > exp_b: the shift amount SHALL be d = exp_a - exp_b, the operand shifted SHALL be B, OUT_EXP SHALL be exp_a, and OUT_SWAP SHALL be 0.
REQ-026 When exp_b > exp_a: the operand shifted SHALL be A, OUT_EXP SHALL be exp_b, and OUT_SWAP SHALL be 1.
REQ-027 When the exponents are equal: there SHALL be no shift, STICKY_BIT SHALL be 0, OUT_SWAP SHALL be 0, and OUT_EXP SHALL be the common exponent.
REQ-028 When d < MAN_W+3, the shifted output SHALL be the extended mantissa shifted right by d. STICKY_BIT SHALL be the OR of the d bits shifted out.
REQ-029 When d >= MAN_W+3, the shifted output SHALL be 0 and STICKY_BIT SHALL be the OR of the whole extended mantissa; the difference SHALL be computed at full EXP_W width with no wrap-around.
REQ-030 When either exponent is all-ones: EXC_FLAG SHALL be 1, both mantissas SHALL be 0, OUT_EXP SHALL be all-ones, STICKY_BIT SHALL be 0 and OUT_SWAP SHALL be 0. NAN_FLAG SHALL be 1 iff an all-ones-exponent operand has a nonzero fraction.
REQ-031 EXC_COUNT SHALL increment by 1 on each output transfer with EXC_FLAG=1. EXC_COUNT SHALL hold at 2^CNT_W-1.
REQ-032 While OUT_VALID=0, output data values SHALL be don't-care; only OUT_VALID and EXC_COUNT are defined.

Reset
REQ-033 When RST=1, s1_valid, s2_valid, OUT_VALID, all data outputs, all flags and EXC_COUNT SHALL clear to 0 immediately. IN_READY SHALL read 1 while reset is active and after it.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operand pairs. After release, no stale OUT_VALID SHALL appear.
REQ-035 The first input transfer after reset SHALL be accepted in the first cycle after RST deasserts.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-036 Shift with sticky: A exp 130 frac 0, B exp 126 frac 0x000003, OUT_READY=1 -> two cycles later OUT_VALID=1, OUT_EXP=130, OUT_MANT_A=0x2000000, OUT_MANT_B=0x0200000, STICKY_BIT=1, OUT_SWAP=0.
REQ-037 Full shift-out: A exp 1 frac 0x7FFFFF, B exp 200 -> OUT_MANT_A=0, STICKY_BIT=1, OUT_SWAP=1, OUT_EXP=200.
REQ-038 Exceptions: A exp 255 frac 1 -> EXC_FLAG=1, NAN_FLAG=1, OUT_EXP=255, EXC_COUNT 0->1 on the output transfer. B exp 255 frac 0 -> NAN_FLAG=0.
REQ-039 Backpressure: 4 back-to-back inputs with OUT_READY=0 -> IN_READY drops after 2 accepted. On release, the 4 results SHALL appear in order with none lost or duplicated.
REQ-040 Denormals: both exponents 0, fracs 0x400000 and 0x000001 -> OUT_EXP=1, OUT_MANT_A=0x1000000, OUT_MANT_B=0x0000004, STICKY_BIT=0.
REQ-041 Reset mid-stream: RST pulse with 2 operand pairs in flight -> OUT_VALID=0 and EXC_COUNT=0 immediately, and no result emerges afterwards.
